// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory load/store unit: access sizes, FSM states, lane masks.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Number of bytes past the first one touched by an access of this size.
  function automatic logic [1:0] size_span(size_e s);
    case (s)
      SZ_H:    return 2'd1;
      SZ_W:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Forces the low address bits to the natural alignment of the access.
  function automatic logic [1:0] align_lo(logic [1:0] lo, size_e s);
    case (s)
      SZ_H:    return {lo[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the core's memory stage (master) and the data memory (slave).
interface data_mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated store data, load lane extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = rword[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    be         = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    case (size)
      SZ_B: begin
        be         = MASK_B << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7] & ~is_unsigned}}, rbyte};
      end
      SZ_H: begin
        be         = MASK_H << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15] & ~is_unsigned}}, rhalf};
      end
      SZ_W: begin
        be         = MASK_W;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with valid/ready requests and a LATENCY-edge registered response.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors instead of aligning them.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 1,
  parameter int ADDR_W      = 32
) (
  input logic           clk,
  input logic           rst,
  data_mem_lsu_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

  logic [7:0]    mem [DEPTH_BYTES];
  state_e        state;
  logic [3:0]    cnt;
  logic          ready_q, valid_q, err_q, pend_err;
  logic [31:0]   rdata_q, pend_rdata;

  size_e         size;
  logic          accept, range_err, acc_err;
  logic [ADDR_W:0] last_byte;
  logic [1:0]    addr_lo;
  logic [AW-3:0] word_idx;
  logic [3:0]    be;
  logic [31:0]   rword, wdata_lane, rdata_ext, acc_rdata;

  assign size    = size_e'(bus.req_size);
  assign accept  = bus.req_valid && ready_q;

  // Range is judged on the raw address so a straddling access errors even when alignment would fold it back.
  assign last_byte = {1'b0, bus.req_addr} + (ADDR_W + 1)'(size_span(size));
  assign range_err = last_byte >= (ADDR_W + 1)'(DEPTH_BYTES);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (size == SZ_H && bus.req_addr[0]) ||
                    (size == SZ_W && bus.req_addr[1:0] != 2'b00);
  assign acc_err  = range_err || size == SZ_RSV || misalign;
`else
  assign acc_err  = range_err || size == SZ_RSV;
`endif

  assign addr_lo   = align_lo(bus.req_addr[1:0], size);
  assign word_idx  = bus.req_addr[AW-1:2];
  assign rword     = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                      mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
  assign acc_rdata = (acc_err || bus.req_we) ? '0 : rdata_ext;

  dmem_lane_align u_lane_align (
    .addr_lo    (addr_lo),
    .size       (size),
    .is_unsigned(bus.req_unsigned),
    .wdata      (bus.req_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  // NOTE: the array has no reset so it maps onto RAM; gating on !rst lets a coincident reset cancel the store.
  always_ff @(posedge clk) begin
    if (!rst && accept && bus.req_we && !acc_err) begin
      if (be[0]) mem[{word_idx, 2'd0}] <= wdata_lane[7:0];
      if (be[1]) mem[{word_idx, 2'd1}] <= wdata_lane[15:8];
      if (be[2]) mem[{word_idx, 2'd2}] <= wdata_lane[23:16];
      if (be[3]) mem[{word_idx, 2'd3}] <= wdata_lane[31:24];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state   <= RESP;
              ready_q <= 1'b1;
              valid_q <= 1'b1;
              rdata_q <= acc_rdata;
              err_q   <= acc_err;
            end else begin
              state      <= WAIT;
              ready_q    <= 1'b0;
              cnt        <= CNT_INIT;
              pend_rdata <= acc_rdata;
              pend_err   <= acc_err;
            end
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
            rdata_q <= pend_rdata;
            err_q   <= pend_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Drives three data_mem_lsu instances (LATENCY 1, 3, 4) with one shared stimulus stream and
// compares every cycle against a transaction-level model; directed cases check fixed expected values.
module tb_data_mem_lsu;
  import dmem_pkg::*;

  localparam int NDUT  = 3;
  localparam int DEPTH = 256;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        valid = 1'b0;
  logic        we    = 1'b0;
  logic        uns   = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;

  logic [NDUT-1:0]       o_ready, o_valid, o_err;
  logic [NDUT-1:0][31:0] o_rdata;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_lsu_if #(.ADDR_W(32)) bus ();
    assign bus.req_valid    = valid;
    assign bus.req_we       = we;
    assign bus.req_size     = size;
    assign bus.req_unsigned = uns;
    assign bus.req_addr     = addr;
    assign bus.req_wdata    = wdata;
    assign o_ready[g]       = bus.req_ready;
    assign o_valid[g]       = bus.resp_valid;
    assign o_err[g]         = bus.resp_err;
    assign o_rdata[g]       = bus.resp_rdata;

    data_mem_lsu #(
      .DEPTH_BYTES(DEPTH),
      .LATENCY    (g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .ADDR_W     (32)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  // Reference model: byte array per instance plus "edges until the response shows" per instance.
  int          lats [NDUT] = '{1, 3, 4};
  logic [7:0]  ref_mem [NDUT][DEPTH];
  int          pend [NDUT];
  logic [31:0] pend_rdata [NDUT];
  logic        pend_err [NDUT];
  logic        exp_valid [NDUT];
  logic        exp_err [NDUT];
  logic [31:0] exp_rdata [NDUT];
  logic [32:0] last_resp [NDUT];
  int          resp_cnt [NDUT];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_access(input int g, output logic [31:0] rd, output logic e);
    int          n;
    int unsigned base;
    n  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    rd = '0;
    e  = (size == 2'b11) || (64'(addr) + 64'(n) > 64'(DEPTH));
    if (TRAP && (addr % n) != 0) e = 1'b1;
    if (e) return;
    base = addr - (addr % n);
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[g][base + k] = wdata[8*k +: 8];
    end else begin
      for (int k = 0; k < n; k++) rd[8*k +: 8] = ref_mem[g][base + k];
      if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'h1 << (8*n)) - 32'h1);
    end
  endfunction

  function automatic void model_edge();
    for (int g = 0; g < NDUT; g++) begin
      bit          rdy;
      logic [31:0] rd;
      logic        e;
      rdy          = (pend[g] == 0);
      exp_valid[g] = 1'b0;
      exp_rdata[g] = '0;
      exp_err[g]   = 1'b0;
      if (pend[g] > 0) begin
        pend[g]--;
        if (pend[g] == 0) begin
          exp_valid[g] = 1'b1;
          exp_rdata[g] = pend_rdata[g];
          exp_err[g]   = pend_err[g];
        end
      end
      if (rdy && valid) begin
        model_access(g, rd, e);
        pend[g] = lats[g] - 1;
        if (pend[g] == 0) begin
          exp_valid[g] = 1'b1;
          exp_rdata[g] = rd;
          exp_err[g]   = e;
        end else begin
          pend_rdata[g] = rd;
          pend_err[g]   = e;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int g = 0; g < NDUT; g++) begin
      pend[g]      = 0;
      exp_valid[g] = 1'b0;
      exp_rdata[g] = '0;
      exp_err[g]   = 1'b0;
    end
  endfunction

  function automatic bit busy();
    busy = 1'b0;
    for (int g = 0; g < NDUT; g++) if (pend[g] != 0) busy = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    cyc++;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("dut%0d cyc%0d {ready,valid,err,rdata}", g, cyc),
            {o_ready[g], o_valid[g], o_err[g], o_rdata[g]},
            {pend[g] == 0, exp_valid[g], exp_err[g], exp_rdata[g]});
      if (o_valid[g] === 1'b1) begin
        last_resp[g] = {o_err[g], o_rdata[g]};
        resp_cnt[g]++;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && busy(); i++) tick();
  endtask

  task automatic req(input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    drain();
    for (int g = 0; g < NDUT; g++) last_resp[g] = {1'b1, 32'hA5A5_A5A5};
    we = w; size = s; uns = u; addr = a; wdata = d; valid = 1'b1;
    tick();
    valid = 1'b0;
    drain();
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] rd, input logic e);
    for (int g = 0; g < NDUT; g++)
      check($sformatf("%s dut%0d {err,rdata}", tag, g), last_resp[g], {e, rd});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base [NDUT];
    int b2b [NDUT] = '{12, 4, 3};

    for (int g = 0; g < NDUT; g++) resp_cnt[g] = 0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // Give every byte a known value so later loads are fully predictable.
    for (int w = 0; w < DEPTH / 4; w++) req(1'b1, SZ_W, 1'b0, 32'(w * 4), $urandom);

    req(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF); expect_resp("sw 0x10", 32'h0, 1'b0);
    req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);         expect_resp("lw 0x10", 32'hDEAD_BEEF, 1'b0);
    req(1'b0, SZ_B, 1'b0, 32'h13, 32'h0);         expect_resp("lb 0x13", 32'hFFFF_FFDE, 1'b0);
    req(1'b0, SZ_B, 1'b1, 32'h13, 32'h0);         expect_resp("lbu 0x13", 32'h0000_00DE, 1'b0);

    req(1'b1, SZ_W, 1'b0, 32'h20, 32'h1122_3344);
    req(1'b1, SZ_H, 1'b0, 32'h22, 32'h0000_ABCD);
    req(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);         expect_resp("lw 0x20", 32'hABCD_3344, 1'b0);
    req(1'b0, SZ_H, 1'b0, 32'h22, 32'h0);         expect_resp("lh 0x22", 32'hFFFF_ABCD, 1'b0);
    req(1'b0, SZ_H, 1'b1, 32'h22, 32'h0);         expect_resp("lhu 0x22", 32'h0000_ABCD, 1'b0);

    req(1'b0, SZ_W, 1'b0, 32'h100, 32'h0);        expect_resp("lw 0x100", 32'h0, 1'b1);
    req(1'b1, SZ_W, 1'b0, 32'hFC, 32'h0BAD_CAFE);
    req(1'b1, SZ_W, 1'b0, 32'hFE, 32'hCAFE_F00D); expect_resp("sw 0xfe", 32'h0, 1'b1);
    req(1'b0, SZ_W, 1'b0, 32'hFC, 32'h0);         expect_resp("lw 0xfc", 32'h0BAD_CAFE, 1'b0);
    req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);        expect_resp("size 11", 32'h0, 1'b1);

    req(1'b1, SZ_H, 1'b0, 32'h21, 32'h0000_7777); expect_resp("sh 0x21", 32'h0, TRAP);
    req(1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    expect_resp("lw 0x20 after sh 0x21", TRAP ? 32'hABCD_3344 : 32'hABCD_7777, 1'b0);

    // Back-to-back loads for 12 edges: one response per 1, 3 and 4 edges respectively.
    drain();
    for (int g = 0; g < NDUT; g++) base[g] = resp_cnt[g];
    we = 1'b0; size = SZ_W; addr = 32'h10; valid = 1'b1;
    repeat (12) tick();
    valid = 1'b0;
    for (int g = 0; g < NDUT; g++)
      check($sformatf("back-to-back responses dut%0d", g), resp_cnt[g] - base[g], b2b[g]);
    drain();

    // Reset two edges after accepting a store; a store presented during reset must not land.
    we = 1'b1; size = SZ_W; addr = 32'h8; wdata = 32'h55; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    base[2] = resp_cnt[2];
    rst = 1'b1;
    model_reset();
    wdata = 32'h99; valid = 1'b1;
    repeat (2) tick();
    valid = 1'b0;
    rst = 1'b0;
    check("responses dropped by reset", resp_cnt[2] - base[2], 0);
    check("ready after reset", o_ready, {NDUT{1'b1}});
    req(1'b0, SZ_W, 1'b0, 32'h8, 32'h0);          expect_resp("lw 0x8 after reset", 32'h0000_0055, 1'b0);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
      wdata = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised byte-addressable data memory for the RISC-V datapath, with a valid/ready request port and a registered response port.
- Natively supports byte, half and word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Provides configurable access latency and range/alignment error reporting.
- Sits between the core's execute/memory stage and the data array, replacing the fixed word-only memory.

Parameters:
- DEPTH_BYTES, 256: array size in bytes; power of two, multiple of 4, at least 8.
- LATENCY, 1: cycles from acceptance to response; legal range 1..15.
- ADDR_W, 32: request address width.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request this cycle.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned, input, 1: load zero-extends when 1, sign-extends when 0; ignored for stores and words.
- req_addr, input, ADDR_W: byte address.
- req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid, output, 1: one-cycle response pulse.
- resp_rdata, output, 32: load result; 0 for stores and for errors.
- resp_err, output, 1: request rejected (range, reserved size, or misalignment).

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE, counter=0. The memory array is not reset; contents are retained across reset.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. All request fields are sampled on that edge.
- Stores commit to the array on the accepting edge; byte lanes outside the access are untouched.
  - SB writes byte addr.
  - SH writes addr and addr+1, little-endian.
  - SW writes addr..addr+3, little-endian.
- Loads read the array state as of the accepting edge, which includes stores committed on earlier edges. The selected lane is extracted and sign- or zero-extended per req_unsigned.
- FSM states:
  - IDLE: req_ready=1. On accept, go to RESP if LATENCY==1, else go to WAIT with counter=LATENCY-2.
  - WAIT: req_ready=0. Decrement the counter; at 0, go to RESP.
  - RESP: resp_valid=1 for this cycle, with resp_rdata and resp_err valid, and req_ready=1. On accept, go to RESP or WAIT exactly as from IDLE; otherwise go to IDLE.
- Latency: resp_valid rises LATENCY edges after the accepting edge, with the accepting edge counted as the first. With LATENCY=1, throughput is one request per cycle.
- Outside RESP: resp_valid=0, resp_rdata=0, resp_err=0.
- Error conditions:
  - req_addr >= DEPTH_BYTES, or the last byte of the access beyond DEPTH_BYTES-1.
  - req_size==11.
  - Misalignment, when the optional feature is enabled.
- On error: no array write, resp_rdata=0, resp_err=1, and the normal latency still applies.
- Reset mid-operation: the in-flight response is dropped and no resp_valid is produced. A store already committed on its accepting edge remains committed. If reset coincides with an accepting edge, reset wins and no write occurs.
- req_valid deasserted while not ready: no effect. Requests are never queued.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=00 sets resp_err=1, does not write, and returns resp_rdata=0.
- Undefined: low address bits are forced to natural alignment (half clears bit 0, word clears bits [1:0]) and the access proceeds with no misalignment error. Range and reserved-size errors still apply.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - FSM state encodings IDLE/WAIT/RESP.
  - Lane-mask constants.
- Sub-module dmem_lane_align (combinational):
  - Inputs: addr[1:0], size, unsigned, wdata, raw word.
  - Outputs: 4-bit byte enable, lane-shifted store data, extended load data.
- The top level holds the array, FSM, counter and error logic.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0. LB @0x13 -> 0xFFFFFFDE. LBU @0x13 -> 0x000000DE.
- SW 0x11223344 @0x20, then SH 0xABCD @0x22, then LW @0x20 -> 0xABCD3344. LH @0x22 -> 0xFFFFABCD. LHU @0x22 -> 0x0000ABCD.
- LATENCY=3, LW issued back-to-back -> resp_valid on the 3rd edge after each accept, req_ready low for 2 cycles, next request accepted in the RESP cycle.
- LW @0x100 with DEPTH_BYTES=256 -> resp_err=1, rdata=0. SW @0xFE -> resp_err=1 and word 0xFC unchanged. size=11 -> resp_err=1.
- SH @0x21:
  - With DMEM_MISALIGN_TRAP_EN -> resp_err=1, memory unchanged.
  - Without -> writes 0x20..0x21, resp_err=0.
- LATENCY=4: assert rst 2 cycles after accepting SW 0x55 @0x8 -> no resp_valid, req_ready=1 after reset, later LW @0x8 returns 0x00000055.
